// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues 16-bit word fetches, buffers {word, PC} entries for the decoder,
// and handles redirects, including draining an in-flight request.
// Define INSTR_FETCH_PREFETCH_EN for a two-entry buffer with prefetch overlap (default: one entry).

module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] memAddr,
  output logic        memReq,
  input  logic        memAck,
  input  logic [15:0] memRData,
  output logic [15:0] instr,
  output logic [15:0] instrPC,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [15:0] redirectPC
);

`ifdef INSTR_FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] fetch_pc_r;
  logic [15:0] drain_addr_r;
  logic        mem_req_r;
  logic [15:0] mem_addr_r;

  logic [1:0]  count_r;
  logic [1:0]  count_s;
  logic [15:0] head_word_r;
  logic [15:0] head_word_s;
  logic [15:0] head_pc_r;
  logic [15:0] head_pc_s;
  logic        instr_valid_r;
`ifdef INSTR_FETCH_PREFETCH_EN
  logic [15:0] tail_word_r;
  logic [15:0] tail_word_s;
  logic [15:0] tail_pc_r;
  logic [15:0] tail_pc_s;
`endif

  logic        ack_s;
  logic        push_s;
  logic        pop_s;
  logic [15:0] redirect_pc_s;
  logic [15:0] pc_inc_s;

  // An acknowledge only counts against a request we actually made.
  assign ack_s         = memAck & mem_req_r;
  assign push_s        = (state_r == FETCH) & ack_s & ~redirect;
  assign pop_s         = instr_valid_r & instrReady;
  assign redirect_pc_s = redirectPC & 16'hFFFE;
  assign pc_inc_s      = fetch_pc_r + 16'd2;

  assign instr      = head_word_r;
  assign instrPC    = head_pc_r;
  assign instrValid = instr_valid_r;
  assign memReq     = mem_req_r & ~reset;
  assign memAddr    = reset ? 16'h0000 : mem_addr_r;

  // Next buffer contents: flush on redirect, otherwise pop at the head and append at the tail.
  always_comb begin
    count_s     = count_r;
    head_word_s = head_word_r;
    head_pc_s   = head_pc_r;
`ifdef INSTR_FETCH_PREFETCH_EN
    tail_word_s = tail_word_r;
    tail_pc_s   = tail_pc_r;
`endif
    if (redirect) begin
      count_s = 2'd0;
    end else if (pop_s && push_s) begin
`ifdef INSTR_FETCH_PREFETCH_EN
      if (count_r == 2'd2) begin
        head_word_s = tail_word_r;
        head_pc_s   = tail_pc_r;
        tail_word_s = memRData;
        tail_pc_s   = fetch_pc_r;
      end else begin
        head_word_s = memRData;
        head_pc_s   = fetch_pc_r;
      end
`else
      head_word_s = memRData;
      head_pc_s   = fetch_pc_r;
`endif
      count_s = count_r;
    end else if (pop_s) begin
`ifdef INSTR_FETCH_PREFETCH_EN
      head_word_s = tail_word_r;
      head_pc_s   = tail_pc_r;
`endif
      count_s = count_r - 2'd1;
    end else if (push_s) begin
      if (count_r == 2'd0) begin
        head_word_s = memRData;
        head_pc_s   = fetch_pc_r;
      end else begin
`ifdef INSTR_FETCH_PREFETCH_EN
        tail_word_s = memRData;
        tail_pc_s   = fetch_pc_r;
`else
        head_word_s = head_word_r;
`endif
      end
      count_s = count_r + 2'd1;
    end else begin
      count_s = count_r;
    end
  end

  // Buffer storage and the decoder-facing output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r       <= 2'd0;
      head_word_r   <= 16'h0000;
      head_pc_r     <= 16'h0000;
      instr_valid_r <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      tail_word_r   <= 16'h0000;
      tail_pc_r     <= 16'h0000;
`endif
    end else begin
      count_r       <= count_s;
      head_word_r   <= head_word_s;
      head_pc_r     <= head_pc_s;
      instr_valid_r <= (count_s != 2'd0);
`ifdef INSTR_FETCH_PREFETCH_EN
      tail_word_r   <= tail_word_s;
      tail_pc_r     <= tail_pc_s;
`endif
    end
  end

  // Fetch FSM; memReq/memAddr are registered as the request for the coming cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= FETCH;
      fetch_pc_r   <= 16'h0000;
      drain_addr_r <= 16'h0000;
      mem_req_r    <= 1'b1;
      mem_addr_r   <= 16'h0000;
    end else begin
      case (state_r)
        FETCH: begin
          if (redirect) begin
            fetch_pc_r <= redirect_pc_s;
            if (mem_req_r && !memAck) begin
              // Request still in flight: hold its address until memory answers.
              state_r      <= DRAIN;
              drain_addr_r <= fetch_pc_r;
              mem_req_r    <= 1'b1;
              mem_addr_r   <= fetch_pc_r;
            end else begin
              state_r    <= FETCH;
              mem_req_r  <= (count_s < DEPTH);
              mem_addr_r <= redirect_pc_s;
            end
          end else if (push_s) begin
            fetch_pc_r <= pc_inc_s;
            mem_req_r  <= (count_s < DEPTH);
            mem_addr_r <= pc_inc_s;
          end else begin
            mem_req_r  <= (count_s < DEPTH);
            mem_addr_r <= fetch_pc_r;
          end
        end
        DRAIN: begin
          if (redirect) begin
            fetch_pc_r <= redirect_pc_s;
          end else begin
            fetch_pc_r <= fetch_pc_r;
          end
          if (memAck) begin
            state_r    <= FETCH;
            mem_req_r  <= (count_s < DEPTH);
            mem_addr_r <= redirect ? redirect_pc_s : fetch_pc_r;
          end else begin
            state_r    <= DRAIN;
            mem_req_r  <= 1'b1;
            mem_addr_r <= drain_addr_r;
          end
        end
        default: begin
          state_r    <= FETCH;
          mem_req_r  <= 1'b0;
          mem_addr_r <= fetch_pc_r;
        end
      endcase
    end
  end

endmodule
